muldiv_execute_ctrl: RTL



---
 rtl/muldiv_execute_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/muldiv_execute_ctrl.sv
// Multi-cycle radix-2 multiply/divide sequencer with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_TERM_EN: multiply exits CALC once the remaining multiplier is zero.
module muldiv_execute_ctrl #(
   parameter int LEN    = 32,
   parameter int NB_CNT = 6
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   input  logic [1:0]     i_op,
   input  logic [LEN-1:0] i_dato_a,
   input  logic [LEN-1:0] i_dato_b,
   input  logic           i_flush,
   output logic           o_busy,
   output logic           o_done,
   output logic           o_div_by_zero,
   output logic [LEN-1:0] o_hi,
   output logic [LEN-1:0] o_lo
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nx;
   logic [NB_CNT-1:0]   cnt;
   logic                is_div, sign_a, sign_b, dbz;
   logic [2*LEN-1:0]    opnd;   // shifted multiplicand (mul) or divisor in low bits (div)
   logic [LEN-1:0]      shreg;  // multiplier (mul) or dividend shifting into quotient (div)
   logic [2*LEN-1:0]    acc;    // product (mul) or remainder in low bits (div)

   logic                sa, sb, divzero_case, accept, last, q_bit;
   logic [LEN-1:0]      abs_a, abs_b, rem_nx, quot_nx, quot_f, rem_f;
   logic [LEN:0]        rem_sh, rem_diff;
   logic [2*LEN-1:0]    mul_acc_nx, prod;

   assign sa           = i_op[0] & i_dato_a[LEN-1];
   assign sb           = i_op[0] & i_dato_b[LEN-1];
   assign abs_a        = sa ? -i_dato_a : i_dato_a;
   assign abs_b        = sb ? -i_dato_b : i_dato_b;
   assign divzero_case = i_op[1] & (i_dato_b == '0);
   assign accept       = ((state == IDLE) || (state == DONE)) & i_start & ~i_flush;

   // One iteration of shift-add multiply and restoring divide.
   assign mul_acc_nx = acc + (shreg[0] ? opnd : '0);
   assign rem_sh     = {acc[LEN-1:0], shreg[LEN-1]};
   assign rem_diff   = rem_sh - {1'b0, opnd[LEN-1:0]};
   assign q_bit      = ~rem_diff[LEN];
   assign rem_nx     = q_bit ? rem_diff[LEN-1:0] : rem_sh[LEN-1:0];
   assign quot_nx    = {shreg[LEN-2:0], q_bit};

   assign prod   = (sign_a ^ sign_b) ? -mul_acc_nx : mul_acc_nx;
   assign quot_f = (sign_a ^ sign_b) ? -quot_nx : quot_nx;
   assign rem_f  = sign_a ? -rem_nx : rem_nx;

`ifdef MULDIV_EARLY_TERM_EN
   // Accumulating into a left-shifted multiplicand keeps the product aligned on early exit.
   assign last = (cnt == NB_CNT'(LEN-1)) | (~is_div & (shreg[LEN-1:1] == '0));
`else
   assign last = (cnt == NB_CNT'(LEN-1));
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      o_busy   = 1'b0;
      case (state)
         IDLE, DONE: begin
            state_nx = IDLE;
            if (accept) begin
               state_nx = divzero_case ? DONE : CALC;
               o_busy   = ~divzero_case;
            end
         end
         CALC: begin
            o_busy = 1'b1;
            if (i_flush)   state_nx = IDLE;
            else if (last) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign o_done        = (state == DONE);
   assign o_div_by_zero = dbz;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dbz    <= 1'b0;
         opnd   <= '0;
         shreg  <= '0;
         acc    <= '0;
         o_hi   <= '0;
         o_lo   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               dbz <= 1'b0;
               if (accept) begin
                  if (divzero_case) begin
                     o_lo <= '1;
                     o_hi <= i_dato_a;
                     dbz  <= 1'b1;
                  end else begin
                     cnt    <= '0;
                     is_div <= i_op[1];
                     sign_a <= sa;
                     sign_b <= sb;
                     opnd   <= {{LEN{1'b0}}, (i_op[1] ? abs_b : abs_a)};
                     shreg  <= i_op[1] ? abs_a : abs_b;
                     acc    <= '0;
                  end
               end
            end
            CALC: begin
               if (!i_flush) begin
                  cnt <= cnt + 1'b1;
                  if (is_div) begin
                     acc   <= {{LEN{1'b0}}, rem_nx};
                     shreg <= quot_nx;
                  end else begin
                     acc   <= mul_acc_nx;
                     shreg <= shreg >> 1;
                     opnd  <= opnd << 1;
                  end
                  if (last) begin
                     if (is_div) begin
                        o_lo <= quot_f;
                        o_hi <= rem_f;
                     end else begin
                        o_lo <= prod[LEN-1:0];
                        o_hi <= prod[2*LEN-1:LEN];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
